// File: rtl/clock_pkg.sv
// Shared types for the alarm-clock mode controller: one-hot state codes
// and the idle-counter width.
package clock_pkg;

    // One-hot state encodings; the raw 6-bit value is also the debug output.
    typedef enum logic [5:0] {
        CLOCK    = 6'b000001,
        SET_TM   = 6'b000010,
        SET_ALRM = 6'b000100,
        SW_STOP  = 6'b001000,
        SW_RUN   = 6'b010000,
        SW_LAP   = 6'b100000
    } clk_state_t;

    // Idle counter width; covers IDLE_CYC up to 65536.
    localparam int IDLE_CNT_W = 16;

endpackage

// File: rtl/idle_timer.sv
// Idle timer for the set modes. Counts enabled cycles since the last
// clear and flags one cycle of timeout when the count reaches IDLE_CYC-1.
module idle_timer
    import clock_pkg::*;
#(
    parameter int IDLE_CYC = 1500
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [IDLE_CNT_W-1:0] LAST = IDLE_CNT_W'(IDLE_CYC - 1);

    logic [IDLE_CNT_W-1:0] cnt;

    // Activity in the same cycle as the terminal count suppresses the timeout.
    assign timeout = en && !clr && (cnt == LAST);

    // Count only while enabled; restart on activity, when disabled, or after firing.
    always_ff @(posedge clk) begin
        if (rst || !en || clr || timeout)
            cnt <= '0;
        else
            cnt <= cnt + IDLE_CNT_W'(1);
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Alarm-clock mode controller: time/alarm set modes with idle timeout,
// stopwatch run/stop/lap/clear. All outputs are decoded from registers.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int NUM_ALARMS = 2,
    parameter int LAP_EN     = 1,
    parameter int IDLE_CYC   = 1500,
    localparam int AW        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_time,
    input  logic          stop_watch,
    input  logic          set_alarm,
    input  logic          strtStp,
    input  logic          lap,
    input  logic          pb_activity,
    output logic          enable_time,
    output logic          enable_sw,
    output logic          sel_sw,
    output logic          sel_alarm,
    output logic [AW-1:0] alarm_idx,
    output logic          en_time_chng,
    output logic          en_alarm_chng,
    output logic          freeze_sw_disp,
    output logic          clr_sw,
    output logic [5:0]    state
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_ALARMS - 1);
    localparam logic          LAP_ON   = (LAP_EN != 0);

    logic [5:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          clr_sw_q, clr_sw_d;
    logic          in_set, mode_ack, timeout;

    // A mode pulse accepted in a set mode counts as activity, so it beats
    // a coincident timeout and restarts the idle count.
    assign in_set   = (state_q == SET_TM) || (state_q == SET_ALRM);
    assign mode_ack = ((state_q == SET_TM) && set_time) ||
                      ((state_q == SET_ALRM) && set_alarm);

    idle_timer #(.IDLE_CYC(IDLE_CYC)) u_idle (
        .clk     (clk),
        .rst     (rst),
        .clr     (pb_activity | mode_ack),
        .en      (in_set),
        .timeout (timeout)
    );

    // Next-state, alarm index and clear-pulse logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_sw_d = 1'b0;
        case (state_q)
            CLOCK: begin
                if (stop_watch)
                    state_d = SW_STOP;
                else if (set_alarm) begin
                    state_d = SET_ALRM;
                    idx_d   = '0;
                end else if (set_time)
                    state_d = SET_TM;
            end
            SET_TM: begin
                if (set_time || timeout)
                    state_d = CLOCK;
            end
            SET_ALRM: begin
                if (set_alarm) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = CLOCK;
                        idx_d   = '0;
                    end else
                        idx_d = idx_q + AW'(1);
                end else if (timeout) begin
                    state_d = CLOCK;
                    idx_d   = '0;
                end
            end
            SW_STOP: begin
                if (stop_watch)
                    state_d = CLOCK;
                else if (strtStp)
                    state_d = SW_RUN;
                else if (lap && LAP_ON)
                    clr_sw_d = 1'b1;
            end
            SW_RUN: begin
                if (stop_watch)
                    state_d = CLOCK;
                else if (strtStp)
                    state_d = SW_STOP;
                else if (lap && LAP_ON)
                    state_d = SW_LAP;
            end
            SW_LAP: begin
                if (stop_watch)
                    state_d = CLOCK;
                else if (strtStp)
                    state_d = SW_STOP;
                else if (lap)
                    state_d = SW_RUN;
            end
            default: begin
                // Non-one-hot value: recover to the idle clock display.
                state_d = CLOCK;
                idx_d   = '0;
            end
        endcase
    end

    // State, alarm index and clear flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLOCK;
            idx_q    <= '0;
            clr_sw_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            clr_sw_q <= clr_sw_d;
        end
    end

    // Moore output decode.
    assign state          = state_q;
    assign enable_time    = (state_q != SET_TM);
    assign enable_sw      = (state_q == SW_RUN) || (state_q == SW_LAP);
    assign sel_sw         = (state_q == SW_STOP) || (state_q == SW_RUN) || (state_q == SW_LAP);
    assign sel_alarm      = (state_q == SET_ALRM);
    assign en_alarm_chng  = (state_q == SET_ALRM);
    assign en_time_chng   = (state_q == SET_TM);
    assign freeze_sw_disp = (state_q == SW_LAP);
    assign alarm_idx      = idx_q;
    assign clr_sw         = clr_sw_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: two instances (3 alarms with lap, 1 alarm
// without lap and a short idle window) driven by the same pulses and
// compared every cycle against a behavioural model.
module tb_clock_mode_ctrl;

    localparam int NA0 = 3, IDLE0 = 1500;
    localparam int NA1 = 1, IDLE1 = 20;

    localparam logic [5:0] P_ST = 6'h01, P_SW = 6'h02, P_SA = 6'h04,
                           P_SS = 6'h08, P_LP = 6'h10, P_PB = 6'h20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_time = 0, stop_watch = 0, set_alarm = 0, strtStp = 0, lap = 0, pb_activity = 0;

    always #5 clk = ~clk;

    logic et0, es0, ss0, sa0, etc0, eac0, fz0, cs0;
    logic [1:0] ai0;
    logic [5:0] st0;
    logic et1, es1, ss1, sa1, etc1, eac1, fz1, cs1;
    logic [0:0] ai1;
    logic [5:0] st1;

    clock_mode_ctrl #(.NUM_ALARMS(NA0), .LAP_EN(1), .IDLE_CYC(IDLE0)) dut0 (
        .clk(clk), .rst(rst), .set_time(set_time), .stop_watch(stop_watch),
        .set_alarm(set_alarm), .strtStp(strtStp), .lap(lap), .pb_activity(pb_activity),
        .enable_time(et0), .enable_sw(es0), .sel_sw(ss0), .sel_alarm(sa0),
        .alarm_idx(ai0), .en_time_chng(etc0), .en_alarm_chng(eac0),
        .freeze_sw_disp(fz0), .clr_sw(cs0), .state(st0));

    clock_mode_ctrl #(.NUM_ALARMS(NA1), .LAP_EN(0), .IDLE_CYC(IDLE1)) dut1 (
        .clk(clk), .rst(rst), .set_time(set_time), .stop_watch(stop_watch),
        .set_alarm(set_alarm), .strtStp(strtStp), .lap(lap), .pb_activity(pb_activity),
        .enable_time(et1), .enable_sw(es1), .sel_sw(ss1), .sel_alarm(sa1),
        .alarm_idx(ai1), .en_time_chng(etc1), .en_alarm_chng(eac1),
        .freeze_sw_disp(fz1), .clr_sw(cs1), .state(st1));

    // Model mode numbers: 0 clock, 1 set time, 2 set alarm, 3 sw stopped,
    // 4 sw running, 5 sw lap. tref = first cycle of the current idle window.
    typedef struct {
        int st;
        int idx;
        int tref;
        bit clrsw;
    } mdl_t;

    int   checks = 0, failures = 0;
    int   cyc = 0;
    bit   chk_en = 0;
    bit   ever_clr1 = 0;
    mdl_t m0 = '{0, 0, 0, 0};
    mdl_t m1 = '{0, 0, 0, 0};

    function automatic mdl_t mstep(mdl_t m, logic [5:0] v, logic r, int nal, bit lapen,
                                   int idle, int c);
        mdl_t n;
        bit b_st, b_sw, b_sa, b_ss, b_lp, b_pb, setm, acc, tmo;
        {b_pb, b_lp, b_ss, b_sa, b_sw, b_st} = v;
        n = m;
        n.clrsw = 0;
        if (r) begin
            n.st  = 0;
            n.idx = 0;
            return n;
        end
        setm = (m.st == 1) || (m.st == 2);
        acc  = (m.st == 1 && b_st) || (m.st == 2 && b_sa);
        tmo  = setm && !b_pb && !acc && ((c - m.tref) == idle - 1);
        case (m.st)
            0: if (b_sw) n.st = 3;
               else if (b_sa) begin n.st = 2; n.idx = 0; end
               else if (b_st) n.st = 1;
            1: if (b_st || tmo) n.st = 0;
            2: if (b_sa) begin
                   if (m.idx == nal - 1) begin n.st = 0; n.idx = 0; end
                   else n.idx = m.idx + 1;
               end else if (tmo) begin n.st = 0; n.idx = 0; end
            3: if (b_sw) n.st = 0; else if (b_ss) n.st = 4; else if (b_lp && lapen) n.clrsw = 1;
            4: if (b_sw) n.st = 0; else if (b_ss) n.st = 3; else if (b_lp && lapen) n.st = 5;
            5: if (b_sw) n.st = 0; else if (b_ss) n.st = 3; else if (b_lp) n.st = 4;
            default: n.st = 0;
        endcase
        if ((n.st == 1 || n.st == 2) && (!setm || b_pb || acc))
            n.tref = c + 1;
        return n;
    endfunction

    // Expected output bundle: {state, en_time, en_sw, sel_sw, sel_alarm, idx[2:0],
    // en_time_chng, en_alarm_chng, freeze, clr_sw}
    function automatic logic [16:0] mexp(mdl_t m);
        logic [5:0] oh;
        oh = 6'(1 << m.st);
        return {oh, m.st != 1, m.st >= 4, m.st >= 3, m.st == 2, 3'(m.idx),
                m.st == 1, m.st == 2, m.st == 5, m.clrsw};
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model with the inputs sampled at each edge.
    always @(posedge clk) begin
        logic [5:0] v;
        v  = {pb_activity, lap, strtStp, set_alarm, stop_watch, set_time};
        m0 = mstep(m0, v, rst, NA0, 1'b1, IDLE0, cyc);
        m1 = mstep(m1, v, rst, NA1, 1'b0, IDLE1, cyc);
        cyc++;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("dut0_outputs", {st0, et0, es0, ss0, sa0, 3'(ai0), etc0, eac0, fz0, cs0}, mexp(m0));
            cmp("dut1_outputs", {st1, et1, es1, ss1, sa1, 3'(ai1), etc1, eac1, fz1, cs1}, mexp(m1));
            if (cs1) ever_clr1 = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [5:0] v);
        {pb_activity, lap, strtStp, set_alarm, stop_watch, set_time} = v;
    endtask

    task automatic pulse(logic [5:0] v);
        drive(v);
        tick();
        drive(6'h00);
    endtask

    initial begin
        // Reset for two clocks.
        drive(6'h00);
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk_en = 1;
        cmp("rst_state", st0, 6'h01);
        cmp("rst_en_time", et0, 1);
        cmp("rst_others", {es0, ss0, sa0, ai0, etc0, eac0, fz0, cs0}, 0);

        // Step through three alarm set-points and back to CLOCK.
        pulse(P_SA);
        cmp("alrm0_state", st0, 6'h04);
        cmp("alrm0_idx", ai0, 0);
        pulse(P_SA);
        cmp("alrm1_idx", ai0, 1);
        pulse(P_SA);
        cmp("alrm2_idx", ai0, 2);
        cmp("alrm2_sel", {sa0, eac0}, 2'b11);
        pulse(P_SA);
        cmp("alrm_exit_state", st0, 6'h01);
        cmp("alrm_exit_idx", ai0, 0);
        cmp("model_pin_alrm", m0.st, 0);

        // Set time with periodic activity, then let it time out.
        pulse(P_ST);
        cmp("settm_state", st0, 6'h02);
        cmp("settm_en_time", {et0, etc0}, 2'b01);
        for (int i = 0; i < 5000; i++) begin
            pb_activity = ((i % 1000) == 999);
            tick();
        end
        pb_activity = 0;
        cmp("settm_held", st0, 6'h02);
        repeat (IDLE0 - 1) tick();
        cmp("settm_before_timeout", st0, 6'h02);
        tick();
        cmp("settm_timeout_state", st0, 6'h01);
        cmp("settm_timeout_chng", etc0, 0);
        cmp("model_pin_timeout", m0.st, 0);

        // Stopwatch run / lap / stop / clear.
        pulse(P_SW);
        cmp("sw_stop_state", st0, 6'h08);
        pulse(P_SS);
        cmp("sw_run_state", st0, 6'h10);
        pulse(P_LP);
        cmp("sw_lap_state", st0, 6'h20);
        cmp("sw_lap_outs", {fz0, es0}, 2'b11);
        cmp("nolap_run_state", st1, 6'h10);
        pulse(P_SS);
        cmp("sw_lap_stop", st0, 6'h08);
        cmp("sw_lap_stop_frz", fz0, 0);
        pulse(P_LP);
        cmp("sw_clr_high", cs0, 1);
        cmp("nolap_clr_low", cs1, 0);
        tick();
        cmp("sw_clr_drop", cs0, 0);
        cmp("sw_clr_stay", st0, 6'h08);

        // Simultaneous pulses.
        pulse(P_SS);
        pulse(P_SW | P_SS);
        cmp("sim_sw_ss", st0, 6'h01);
        pulse(P_ST | P_SW);
        cmp("sim_st_sw", st0, 6'h08);
        pulse(P_SW);
        cmp("sw_exit", st0, 6'h01);

        // Reset while in lap.
        pulse(P_SW);
        pulse(P_SS);
        pulse(P_LP);
        cmp("pre_rst_lap", st0, 6'h20);
        rst = 1;
        tick();
        rst = 0;
        cmp("rst_from_lap", st0, 6'h01);
        cmp("rst_from_lap_frz", fz0, 0);

        // Random pulse traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [5:0] v;
            v[0] = ($urandom_range(7) == 0);
            v[1] = ($urandom_range(15) == 0);
            v[2] = ($urandom_range(7) == 0);
            v[3] = ($urandom_range(5) == 0);
            v[4] = ($urandom_range(5) == 0);
            v[5] = ($urandom_range(40) == 0);
            drive(v);
            rst = ($urandom_range(499) == 0);
            tick();
        end
        drive(6'h00);
        rst = 0;
        repeat (3) tick();
        cmp("nolap_never_clr", ever_clr1, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
